// File: rtl/csat_pkg.sv
// Shared types and benchmark defaults for the CSAT sweep controller slice.
package csat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // Defaults for the 7x4 multiplier factorization miter.
    localparam int unsigned MUL_N_IN     = 32'd11;
    localparam int unsigned MUL_PIPE_LAT = 32'd0;

endpackage

// File: rtl/sweep_align_pipe.sv
// Delays {valid, cand} by PIPE_LAT cycles so each candidate lines up with the
// benchmark's sat output; a plain wire when PIPE_LAT is zero.
module sweep_align_pipe #(
    parameter int unsigned N_IN     = 32'd11,
    parameter int unsigned PIPE_LAT = 32'd0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_cand,
    output logic            out_valid,
    output logic [N_IN-1:0] out_cand
);

    generate
        if (PIPE_LAT == 0) begin : g_pass
            logic unused_s;
            assign unused_s  = ^{clk, reset, flush};
            assign out_valid = in_valid;
            assign out_cand  = in_cand;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] valid_r;
            logic [N_IN-1:0]     cand_r [PIPE_LAT];

            // Shift register; flush kills in-flight entries after a hit or restart.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    valid_r <= '0;
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        cand_r[i] <= '0;
                    end
                end else begin
                    valid_r[0] <= in_valid;
                    cand_r[0]  <= in_cand;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        valid_r[i] <= valid_r[i-1];
                        cand_r[i]  <= cand_r[i-1];
                    end
                end
            end

            assign out_valid = valid_r[PIPE_LAT-1];
            assign out_cand  = cand_r[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sat_sweep_controller.sv
// Exhaustive input sweep of a CSAT benchmark: issues candidates in ascending
// order, checks latency-aligned sat results and reports the first hit or UNSAT.
module sat_sweep_controller
    import csat_pkg::*;
#(
    parameter int unsigned N_IN     = MUL_N_IN,
    parameter int unsigned PIPE_LAT = MUL_PIPE_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] cand,
    input  logic            sat_in,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic [N_IN-1:0] solution,
    output logic [N_IN:0]   evals
);

    localparam logic [N_IN-1:0] CAND_MAX  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] CAND_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   EVALS_MAX = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0]   EVALS_ONE = {{N_IN{1'b0}}, 1'b1};

    sweep_state_t    state_r, state_next_s;
    logic [N_IN-1:0] cand_r, solution_r;
    logic [N_IN:0]   evals_r;
    logic            busy_r, done_r, found_r;
    logic            al_valid_s, check_s, hit_s, start_ok_s, abort_clr_s, flush_s;
    logic [N_IN-1:0] al_cand_s;

    assign flush_s = start_ok_s | abort_clr_s | hit_s;

    sweep_align_pipe #(
        .N_IN     (N_IN),
        .PIPE_LAT (PIPE_LAT)
    ) u_align (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_s),
        .in_valid  (state_r == SWEEP),
        .in_cand   (cand_r),
        .out_valid (al_valid_s),
        .out_cand  (al_cand_s)
    );

    // Next-state decode; abort beats start, a hit beats the last-candidate exit.
    always_comb begin
        state_next_s = state_r;
        start_ok_s   = 1'b0;
        abort_clr_s  = 1'b0;
        hit_s        = 1'b0;
        check_s      = ((state_r == SWEEP) || (state_r == DRAIN)) && al_valid_s;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_next_s = SWEEP;
                    start_ok_s   = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SWEEP, DRAIN: begin
                if (abort) begin
                    state_next_s = IDLE;
                    abort_clr_s  = 1'b1;
                end else if (check_s && sat_in) begin
                    state_next_s = DONE;
                    hit_s        = 1'b1;
                end else if (check_s && (al_cand_s == CAND_MAX)) begin
                    state_next_s = DONE;
                end else if ((state_r == SWEEP) && (cand_r == CAND_MAX)) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (start) begin
                    state_next_s = SWEEP;
                    start_ok_s   = 1'b1;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, candidate counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cand_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            found_r    <= 1'b0;
            solution_r <= '0;
            evals_r    <= '0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == SWEEP) || (state_next_s == DRAIN);
            done_r  <= (state_next_s == DONE);

            if (start_ok_s || abort_clr_s) begin
                cand_r <= '0;
            end else if ((state_r == SWEEP) && (state_next_s == SWEEP)) begin
                cand_r <= cand_r + CAND_ONE;
            end else begin
                cand_r <= cand_r;
            end

            if (start_ok_s || abort_clr_s) begin
                evals_r <= '0;
            end else if (check_s && (evals_r != EVALS_MAX)) begin
                evals_r <= evals_r + EVALS_ONE;
            end else begin
                evals_r <= evals_r;
            end

            if (start_ok_s || abort_clr_s) begin
                found_r    <= 1'b0;
                solution_r <= '0;
            end else if (hit_s) begin
                found_r    <= 1'b1;
                solution_r <= al_cand_s;
            end else begin
                found_r    <= found_r;
                solution_r <= solution_r;
            end
        end
    end

    assign cand     = cand_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign found    = found_r;
    assign solution = solution_r;
    assign evals    = evals_r;

endmodule
